// File: rtl/wvb_storage_if.sv
// Port bundle between the waveform-buffer write controller / readout arbiter
// and the waveform buffer storage.
interface wvb_storage_if #(
  parameter int P_DATA_WIDTH         = 22,
  parameter int P_ADR_WIDTH          = 12,
  parameter int P_HDR_WIDTH          = 80,
  parameter int P_HDR_ADR_WIDTH      = 8,
  parameter int P_N_WVF_IN_BUF_WIDTH = 16
);
  logic                            eoe_in;
  logic [P_DATA_WIDTH-1:0]         wvb_data_in;
  logic [P_ADR_WIDTH-1:0]          wvb_wr_addr;
  logic                            wvb_wrreq;
  logic [P_ADR_WIDTH-1:0]          wvb_rd_addr;
  logic [P_DATA_WIDTH-1:0]         wvb_data_out;
  logic [P_HDR_WIDTH-1:0]          hdr_data_in;
  logic                            hdr_wrreq;
  logic                            hdr_rdreq;
  logic [P_HDR_WIDTH-1:0]          hdr_data_out;
  logic                            hdr_full;
  logic                            hdr_empty;
  logic                            hdr_afull;
  logic [P_N_WVF_IN_BUF_WIDTH-1:0] n_wvf_in_buf;
  logic                            hdr_drop;
  logic                            hdr_udf;
  logic [15:0]                     drop_cnt;
  logic [P_HDR_ADR_WIDTH:0]        hwm;
  logic                            clr_stats;

  modport master (
    output eoe_in, wvb_data_in, wvb_wr_addr, wvb_wrreq, wvb_rd_addr,
           hdr_data_in, hdr_wrreq, hdr_rdreq, clr_stats,
    input  wvb_data_out, hdr_data_out, hdr_full, hdr_empty, hdr_afull,
           n_wvf_in_buf, hdr_drop, hdr_udf, drop_cnt, hwm
  );

  modport slave (
    input  eoe_in, wvb_data_in, wvb_wr_addr, wvb_wrreq, wvb_rd_addr,
           hdr_data_in, hdr_wrreq, hdr_rdreq, clr_stats,
    output wvb_data_out, hdr_data_out, hdr_full, hdr_empty, hdr_afull,
           n_wvf_in_buf, hdr_drop, hdr_udf, drop_cnt, hwm
  );
endinterface

// File: rtl/wvb_storage_param.sv
// Waveform buffer storage: read-first sample RAM plus a header FIFO with
// exact occupancy, almost-full, drop/underflow accounting and high-water mark.
module wvb_storage_param #(
  parameter int P_DATA_WIDTH         = 22,
  parameter int P_ADR_WIDTH          = 12,
  parameter int P_HDR_WIDTH          = 80,
  parameter int P_HDR_ADR_WIDTH      = 8,
  parameter int P_N_WVF_IN_BUF_WIDTH = 16,
  parameter int P_AFULL_THRESH       = 240
) (
  input  logic          clk,
  input  logic          rst,
  wvb_storage_if.slave  bus
);
  localparam int AW = P_HDR_ADR_WIDTH;
  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam int unsigned   AFULL_T = P_AFULL_THRESH;

  if (P_N_WVF_IN_BUF_WIDTH < P_HDR_ADR_WIDTH + 1) begin : g_bad_occ_width
    $error("P_N_WVF_IN_BUF_WIDTH must be at least P_HDR_ADR_WIDTH+1");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [P_DATA_WIDTH-1:0] ram [2**P_ADR_WIDTH];
  logic [P_HDR_WIDTH-1:0]  mem [2**AW];
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             count, count_nxt;
  logic                    push_ok, pop_ok;

  // Sample RAM: separate write and registered read give read-first behaviour
  always_ff @(posedge clk) begin
    if (bus.wvb_wrreq) ram[bus.wvb_wr_addr] <= {bus.wvb_data_in[P_DATA_WIDTH-1:1], bus.eoe_in};
  end

  always_ff @(posedge clk) begin
    if (rst) bus.wvb_data_out <= '0;
    else     bus.wvb_data_out <= ram[bus.wvb_rd_addr];
  end

  // A pop frees a slot in the same cycle, so a push at full is accepted alongside it
  always_comb begin
    pop_ok    = bus.hdr_rdreq && (count != '0);
    push_ok   = bus.hdr_wrreq && ((count != DEPTH) || pop_ok);
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + CNT_ONE;
    else if (pop_ok && !push_ok) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= bus.hdr_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp               <= '0;
      rp               <= '0;
      count            <= '0;
      bus.hdr_data_out <= '0;
      bus.hdr_full     <= 1'b0;
      bus.hdr_empty    <= 1'b1;
      bus.hdr_afull    <= 1'b0;
      bus.n_wvf_in_buf <= '0;
      bus.hdr_drop     <= 1'b0;
      bus.hdr_udf      <= 1'b0;
      bus.drop_cnt     <= '0;
      bus.hwm          <= '0;
    end else begin
      if (push_ok) wp <= wp + PTR_ONE;
      if (pop_ok) begin
        rp               <= rp + PTR_ONE;
        bus.hdr_data_out <= mem[rp];
      end
      count            <= count_nxt;
      bus.hdr_full     <= (count_nxt == DEPTH);
      bus.hdr_empty    <= (count_nxt == '0);
      bus.hdr_afull    <= (32'(count_nxt) >= AFULL_T);
      bus.n_wvf_in_buf <= P_N_WVF_IN_BUF_WIDTH'(count_nxt);
      bus.hdr_drop     <= bus.hdr_wrreq && !push_ok;
      bus.hdr_udf      <= bus.hdr_rdreq && !pop_ok;
      // Clear takes priority over a coincident drop
      if (bus.clr_stats) begin
        bus.drop_cnt <= '0;
        bus.hwm      <= count_nxt;
      end else begin
        if (bus.hdr_wrreq && !push_ok) bus.drop_cnt <= sat_inc16(bus.drop_cnt);
        if (count_nxt > bus.hwm)       bus.hwm      <= count_nxt;
      end
    end
  end
endmodule

// File: doc/wvb_storage_param.md
# wvb_storage_param

Parametrised successor to the mDOM waveform buffer storage. Combines an inferred simple-dual-port sample RAM with a generic-depth header FIFO. Adds exact occupancy counting, an almost-full flag, drop and underflow accounting, and an occupancy high-water mark. Sits between the waveform-buffer write controller (sample and header writes) and the readout arbiter (random-access sample reads, header pops).

## Interface
- P_DATA_WIDTH, 22: sample word width; bit 0 is replaced by the end-of-event flag.
- P_ADR_WIDTH, 12: sample RAM address width; depth is 2^P_ADR_WIDTH.
- P_HDR_WIDTH, 80: header word width.
- P_HDR_ADR_WIDTH, 8: header FIFO address width; depth D = 2^P_HDR_ADR_WIDTH.
- P_N_WVF_IN_BUF_WIDTH, 16: occupancy output width; must be ≥ P_HDR_ADR_WIDTH+1, otherwise elaboration fails.
- P_AFULL_THRESH, 240: almost-full threshold, in header entries.

Ports:
- clk  in  1  sole clock
- rst  in  1  reset, synchronous, active-high
- eoe_in  in  1  end-of-event flag, stored in bit 0
- wvb_data_in  in  P_DATA_WIDTH  sample; bit 0 ignored
- wvb_wr_addr  in  P_ADR_WIDTH  sample write address
- wvb_wrreq  in  1  sample write strobe
- wvb_rd_addr  in  P_ADR_WIDTH  sample read address
- wvb_data_out  out  P_DATA_WIDTH  registered sample read data
- hdr_data_in  in  P_HDR_WIDTH  header write data
- hdr_wrreq  in  1  header push
- hdr_rdreq  in  1  header pop
- hdr_data_out  out  P_HDR_WIDTH  registered popped header
- hdr_full  out  1  count == D
- hdr_empty  out  1  count == 0
- hdr_afull  out  1  count ≥ P_AFULL_THRESH
- n_wvf_in_buf  out  P_N_WVF_IN_BUF_WIDTH  header count, zero-extended, range 0..D
- hdr_drop  out  1  1-cycle pulse: push rejected
- hdr_udf  out  1  1-cycle pulse: pop while empty
- drop_cnt  out  16  saturating count of rejected pushes
- hwm  out  P_HDR_ADR_WIDTH+1  maximum count since reset or clr_stats
- clr_stats  in  1  clears drop_cnt and hwm

## Operation
- Sample RAM:
  - When wvb_wrreq=1, writes {wvb_data_in[P_DATA_WIDTH-1:1], eoe_in} to RAM[wvb_wr_addr].
  - Reads every cycle: wvb_data_out <= RAM[wvb_rd_addr].
  - Same-address write and read in one cycle returns the old data (read-first).
  - RAM contents are not cleared by reset.
- Header FIFO:
  - Write pointer wp and read pointer rp, P_HDR_ADR_WIDTH bits each, wrap modulo D.
  - Separate count register, P_HDR_ADR_WIDTH+1 bits.
- Push accepted when hdr_wrreq=1 and (count<D or pop accepted in the same cycle):
  - mem[wp] <= hdr_data_in; wp++.
- Pop accepted when hdr_rdreq=1 and count>0:
  - hdr_data_out <= mem[rp]; rp++.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full, both are accepted; count stays D.
  - When empty, the pop is rejected (hdr_udf pulses) and the push is accepted; count becomes 1. The data is not bypassed.
- Rejected push (full, no pop): data discarded, hdr_drop pulses, drop_cnt increments and saturates at 0xFFFF.
- Rejected pop: hdr_data_out holds its previous value, hdr_udf pulses.
- Flags and counters:
  - hdr_full, hdr_empty, hdr_afull, n_wvf_in_buf and hwm are registered and derived from the post-update count.
  - hwm <= max(hwm, next count).
- clr_stats: drop_cnt <= 0 and hwm <= current next count. If clr_stats coincides with a drop, the clear wins.
- rst:
  - wp, rp, count, drop_cnt and hwm go to 0.
  - All outputs take their reset values, even mid-burst; pending headers are lost.

## Timing
- Reset values:
  - 0: wvb_data_out, hdr_data_out, hdr_full, hdr_afull, n_wvf_in_buf, hdr_drop, hdr_udf, drop_cnt, hwm.
  - 1: hdr_empty.
- Sample read latency: 1 cycle from wvb_rd_addr to wvb_data_out. A write takes effect for a read issued on the following cycle or later.
- Header pop latency: hdr_data_out is valid 1 cycle after an accepted hdr_rdreq.
- Flag latency: flags and n_wvf_in_buf reflect a push or pop 1 cycle after the request edge.
  - hdr_empty deasserts the cycle after the first push.
  - A pop issued that cycle is accepted.
- hdr_drop, hdr_udf and the drop_cnt update occur 1 cycle after the offending request.
- Back-to-back pushes and pops every cycle are sustained: 1 operation per cycle each.

## Test plan
- **Reset and sample RAM:** after reset, check hdr_empty=1, n_wvf_in_buf=0 and every other output 0. Write addr 0x005 with data 0x3FFFFE and eoe=1, then read addr 0x005: wvb_data_out=0x3FFFFF one cycle after the address.
- **Header ordering:** push headers 1..3, then pop 3 times. hdr_data_out shows 1, 2, 3 on consecutive cycles; n_wvf_in_buf goes 3→0; hdr_empty returns to 1.
- **Fill, drop and saturation:** with D=256, push 256 headers; hdr_full=1, hdr_afull=1 (since 240), n_wvf_in_buf=256. Push 2 more: hdr_drop pulses twice, drop_cnt=2, contents unchanged. Force 70000 drops: drop_cnt=0xFFFF.
- **Simultaneous push and pop:**
  - At full: count stays 256, and the new header appears after 255 further pops.
  - At empty: hdr_udf=1, count becomes 1.
- **Wrap and high-water mark:** run 1000 push/pop cycles at occupancy 10 across pointer wrap; data stays in order and hwm=10. Then clr_stats at count 4: hwm=4, drop_cnt=0.
- **Reset mid-burst:** assert rst with count=100; the next cycle shows count 0, hdr_empty=1, hwm=0. A subsequent push and pop returns the new data.
